// File: rtl/seq_gen.sv
// Serial pattern generator: sends PAT_W-bit frames MSB first, repeated with idle gaps.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to every frame.
module seq_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [1:0]       gap_len,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IW-1:0] MSB = IW'(PAT_W - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    GAP  = 3'd2,
`ifdef SEQ_GEN_PARITY_EN
    PAR  = 3'd4,
`endif
    DONE = 3'd3
  } state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [1:0]       gap_q, gap_n;
  logic [IW-1:0]    idx, idx_n;
  logic [1:0]       gctr, gctr_n;
  logic [CNT_W-1:0] fs_n;
  logic             out_n;
  logic             frame_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      idx         <= '0;
      gctr        <= '0;
      frames_sent <= '0;
      out         <= 1'b0;
    end else begin
      state       <= state_n;
      pat_q       <= pat_n;
      cnt_q       <= cnt_n;
      gap_q       <= gap_n;
      idx         <= idx_n;
      gctr        <= gctr_n;
      frames_sent <= fs_n;
      out         <= out_n;
    end
  end

  always_comb begin
    state_n   = state;
    pat_n     = pat_q;
    cnt_n     = cnt_q;
    gap_n     = gap_q;
    idx_n     = idx;
    gctr_n    = gctr;
    fs_n      = frames_sent;
    frame_end = 1'b0;
    out_n     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          pat_n = pattern;
          cnt_n = repeat_cnt;
          gap_n = gap_len;
          fs_n  = '0;
          idx_n = MSB;
          state_n = (repeat_cnt == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (idx == '0) begin
`ifdef SEQ_GEN_PARITY_EN
          state_n = PAR;
`else
          frame_end = 1'b1;
`endif
        end else begin
          idx_n = idx - IW'(1);
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PAR: frame_end = 1'b1;
`endif
      GAP: begin
        if (gctr <= 2'd1) begin
          state_n = SEND;
          idx_n   = MSB;
        end else begin
          gctr_n = gctr - 2'd1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (frame_end) begin
      fs_n = frames_sent + CNT_W'(1);
      if (fs_n == cnt_q) begin
        state_n = DONE;
      end else if (gap_q != 2'd0) begin
        state_n = GAP;
        gctr_n  = gap_q;
      end else begin
        state_n = SEND;
        idx_n   = MSB;
      end
    end

    // abort outranks everything once a transmission is under way
    if (abort && state != IDLE) begin
      state_n = IDLE;
      fs_n    = frames_sent;
    end

    if (state_n == SEND) out_n = pat_n[idx_n];
`ifdef SEQ_GEN_PARITY_EN
    if (state_n == PAR) out_n = ^pat_n;
`endif
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: table of transmissions plus abort/reset sequences.
// Expected streams are hand-packed MSB first into the bits field.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] pattern = '0;
  logic [3:0] repeat_cnt = '0;
  logic [1:0] gap_len = '0;
  logic       out;
  logic       busy;
  logic       done;
  logic [3:0] frames_sent;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_GEN_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  seq_gen #(.PAT_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .gap_len(gap_len),
    .out(out), .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pat;
    logic [3:0]  rep;
    logic [1:0]  gap;
    logic [31:0] bits;
    int          nb;
    int          nbusy;
    logic [3:0]  fs;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] got;
    int nb, nbusy, ndone, done_out;
    bit timeout;
    @(negedge clk);
    pattern = v.pat; repeat_cnt = v.rep; gap_len = v.gap; start = 1'b1;
    @(posedge clk); #1;
    // scramble inputs and keep start high: both must be ignored while busy
    pattern = ~v.pat; repeat_cnt = v.rep + 4'd5; gap_len = v.gap ^ 2'd1;
    got = '0; nb = 0; nbusy = 0; ndone = 0; done_out = 0; timeout = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      nbusy++;
      if (done) begin
        ndone++;
        if (out) done_out++;
      end else begin
        got = {got[30:0], out};
        nb++;
      end
      if (c == 0) start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, " timeout"}, 32'(timeout), 32'd0);
    chk({tag, " stream"}, got, v.bits);
    chk({tag, " nbits"}, 32'(nb), 32'(v.nb));
    chk({tag, " busy_cycles"}, 32'(nbusy), 32'(v.nbusy));
    chk({tag, " done_pulses"}, 32'(ndone), 32'd1);
    chk({tag, " done_out"}, 32'(done_out), 32'd0);
    chk({tag, " idle_out"}, 32'(out), 32'd0);
    chk({tag, " idle_done"}, 32'(done), 32'd0);
    chk({tag, " frames_sent"}, 32'(frames_sent), 32'(v.fs));
  endtask

  initial begin
    int seen;
`ifdef SEQ_GEN_PARITY_EN
    tbl.push_back('{4'b0111, 4'd1, 2'd0, 32'b01111, 5, 6, 4'd1});
    tbl.push_back('{4'b0110, 4'd2, 2'd1, 32'b01100_0_01100, 11, 12, 4'd2});
    tbl.push_back('{4'b1011, 4'd1, 2'd2, 32'b10111, 5, 6, 4'd1});
    tbl.push_back('{4'b0000, 4'd0, 2'd1, 32'b0, 0, 1, 4'd0});
`else
    tbl.push_back('{4'b0110, 4'd1, 2'd0, 32'b0110, 4, 5, 4'd1});
    tbl.push_back('{4'b0110, 4'd3, 2'd2, 32'b0110_00_0110_00_0110, 16, 17, 4'd3});
    tbl.push_back('{4'b1010, 4'd0, 2'd1, 32'b0, 0, 1, 4'd0});
    tbl.push_back('{4'b1011, 4'd2, 2'd1, 32'b1011_0_1011, 9, 10, 4'd2});
    tbl.push_back('{4'b1100, 4'd2, 2'd0, 32'b1100_1100, 8, 9, 4'd2});
    tbl.push_back('{4'b1111, 4'd1, 2'd3, 32'b1111, 4, 5, 4'd1});
    tbl.push_back('{4'b0001, 4'd2, 2'd3, 32'b0001_000_0001, 11, 12, 4'd2});
`endif

    #12;
    chk("reset out", 32'(out), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset frames", 32'(frames_sent), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle out", 32'(out), 32'd0);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // start together with abort in IDLE: abort wins
    @(negedge clk);
    pattern = 4'b1111; repeat_cnt = 4'd1; gap_len = 2'd0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort busy", 32'(busy), 32'd0);
    chk("start_abort out", 32'(out), 32'd0);

    // abort on the 3rd bit of frame 2
    @(negedge clk);
    pattern = 4'b1011; repeat_cnt = 4'd2; gap_len = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (FL + 2) @(posedge clk);
    #1;
    chk("abort pre_bit", 32'(out), 32'd1);
    chk("abort pre_frames", 32'(frames_sent), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort out", 32'(out), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort frames", 32'(frames_sent), 32'd1);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("abort quiet", 32'(seen), 32'd0);

    // asynchronous reset in the middle of frame 2
    @(negedge clk);
    pattern = 4'b1011; repeat_cnt = 4'd3; gap_len = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (FL) @(posedge clk);
    #1;
    chk("rst pre_out", 32'(out), 32'd1);
    chk("rst pre_frames", 32'(frames_sent), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst async out", 32'(out), 32'd0);
    chk("rst async busy", 32'(busy), 32'd0);
    chk("rst async frames", 32'(frames_sent), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy || out) seen++;
    end
    chk("rst no_resume", 32'(seen), 32'd0);
`ifdef SEQ_GEN_PARITY_EN
    run_vec('{4'b1011, 4'd1, 2'd0, 32'b10111, 5, 6, 4'd1}, "rst_restart");
`else
    run_vec('{4'b1011, 4'd1, 2'd0, 32'b1011, 4, 5, 4'd1}, "rst_restart");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The module SHALL have parameter PAT_W, default 4, giving the pattern width in bits.
REQ-002 The module SHALL have parameter CNT_W, default 4, giving the repeat-count width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to begin a transmission; sampled only in IDLE.
REQ-006 Port abort, input, 1 bit: synchronous cancel of the current transmission.
REQ-007 Port pattern, input, PAT_W bits: frame bits, transmitted MSB first.
REQ-008 Port repeat_cnt, input, CNT_W bits: number of frames to send.
REQ-009 Port gap_len, input, 2 bits: number of idle-0 bits inserted between consecutive frames.
REQ-010 Port out, output, 1 bit: registered serial data line.
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse marking normal completion.
REQ-013 Port frames_sent, output, CNT_W bits: count of frames fully transmitted in the current or last transmission.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, PAR, GAP and DONE; PAR exists only under SEQ_GEN_PARITY_EN.
REQ-015 In IDLE with start=1 and abort=0, the block SHALL latch pattern, repeat_cnt and gap_len, clear frames_sent, and move to SEND (or to DONE when repeat_cnt=0).
REQ-016 The first frame bit (pattern[PAT_W-1]) SHALL appear on out in the cycle after start is sampled; each bit SHALL be held exactly one cycle.
REQ-017 After bit 0 of a frame, the block SHALL go to PAR if parity is enabled, otherwise it SHALL increment frames_sent and choose the next state per REQ-018.
REQ-018 After a frame: if frames_sent (after increment) equals the latched repeat_cnt, the next state SHALL be DONE; otherwise it SHALL be GAP when gap_len>0, or SEND directly when gap_len=0.
REQ-019 GAP SHALL drive out=0 for exactly gap_len cycles and then return to SEND with the bit index reloaded to PAT_W-1.
REQ-020 DONE SHALL last one cycle with done=1, out=0 and busy=1, then return to IDLE.
REQ-021 Changes to pattern, repeat_cnt or gap_len while busy=1 SHALL have no effect; start while busy=1 SHALL be ignored.
REQ-022 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with out=0 and done=0; frames_sent SHALL hold its value.
REQ-023 If start and abort are both high in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-024 In IDLE, out SHALL be 0.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, out=0, busy=0, done=0, frames_sent=0 and clear all latched inputs.
REQ-026 Reset asserted mid-frame SHALL truncate the frame, with no done pulse; after release, operation SHALL resume only on a fresh start.

Configuration
REQ-027 With macro SEQ_GEN_PARITY_EN defined, each frame SHALL be followed by one PAR cycle driving the even-parity bit (XOR of the latched pattern) before frames_sent increments; frame length becomes PAT_W+1.
REQ-028 Without SEQ_GEN_PARITY_EN, the PAR state and parity logic SHALL be absent and the frame length SHALL be PAT_W.

Verification
REQ-029 pattern=0110, repeat_cnt=1, gap_len=0, start pulse -> out=0,1,1,0 on cycles 1-4 after start, done=1 on cycle 5, frames_sent=1.
REQ-030 pattern=0110, repeat_cnt=3, gap_len=2 -> out=0110 00 0110 00 0110, followed by the done pulse; busy high for 17 cycles.
REQ-031 repeat_cnt=0, start pulse -> no data bits; done=1 on the cycle after start, frames_sent=0.
REQ-032 pattern=1011, repeat_cnt=2, abort asserted on the 3rd bit of frame 2 -> IDLE next cycle, out=0, done never pulses, frames_sent=1.
REQ-033 rst driven low mid-frame between clock edges -> out, busy and frames_sent clear at once without waiting for clk; start after release re-transmits from the MSB.
REQ-034 With SEQ_GEN_PARITY_EN, pattern=0111, repeat_cnt=1 -> out=0,1,1,1,1 (parity=1), then done.
